// File: rtl/ahb_mem_slave_pkg.sv
// Shared AHB encodings, slave FSM states and latched-control payload for ahb_mem_slave.
package ahb_mem_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    typedef struct packed {
        logic       write;
        logic [2:0] size;
        logic [1:0] offs;
    } ctrl_t;

    // Little-endian byte-lane enables for a transfer of the given size and low address bits.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offs);
        logic [3:0] m;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << offs;
            HSIZE_HALF: m = offs[1] ? 4'b1100 : 4'b0011;
            default:    m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word-organised RAM: byte-enabled synchronous write, asynchronous read; contents survive reset.
module ahb_mem_array #(
    parameter  int unsigned MEM_WORDS = 256,
    localparam int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata_c
);

    logic [31:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave with fixed wait states, ERROR response for bad transfers and
// a write-to-read bypass so back-to-back accesses to one word see merged data.
module ahb_mem_slave
    import ahb_mem_slave_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = 2;

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             hready_q, hready_d;
    logic [1:0]       hresp_q, hresp_d;
    logic [31:0]      hrdata_q, hrdata_d;

    logic             accept_c;
    logic             err_c;
    logic             we_c;
    logic [3:0]       we_be_c;
    logic [IDX_W-1:0] haddr_idx_c;
    logic [IDX_W-1:0] rd_idx_c;
    logic [31:0]      rd_word_c;
    logic [31:0]      rd_merged_c;
    logic             unused_c;

    // Burst type and the BUSY/IDLE distinction carry no meaning for a per-beat addressed RAM.
    assign unused_c = ^{HBURST, HTRANS[0]};

    assign haddr_idx_c = HADDR[IDX_W+1:2];
    assign accept_c    = HSEL && HREADY && HTRANS[1];
    assign err_c       = (HSIZE > HSIZE_WORD)
                      || (HSIZE == HSIZE_HALF && HADDR[0])
                      || (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00)
                      || (HADDR[31:IDX_W+2] != '0);

    // A write commits on the edge that ends its ready data-phase cycle.
    assign we_c     = active_q && hready_q && ctrl_q.write && !HRESET;
    assign we_be_c  = lane_mask(ctrl_q.size, ctrl_q.offs);
    assign rd_idx_c = (state_q == ST_WAIT) ? idx_q : haddr_idx_c;

    ahb_mem_array #(
        .MEM_WORDS(MEM_WORDS)
    ) u_mem (
        .clk    (HCLK),
        .we     (we_c),
        .be     (we_be_c),
        .waddr  (idx_q),
        .wdata  (HWDATA),
        .raddr  (rd_idx_c),
        .rdata_c(rd_word_c)
    );

    // Forward lanes being written on this same edge into the read word.
    always_comb begin
        rd_merged_c = rd_word_c;
        for (int b = 0; b < 4; b++) begin
            if (we_c && idx_q == rd_idx_c && we_be_c[b]) begin
                rd_merged_c[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        hready_d = hready_q;
        hresp_d  = hresp_q;
        hrdata_d = hrdata_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = ST_IDLE;
                    hready_d = 1'b1;
                    if (!ctrl_q.write) begin
                        hrdata_d = rd_merged_c;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ERR1: begin
                state_d  = ST_ERR2;
                hready_d = 1'b1;
                hresp_d  = HRESP_ERROR;
            end
            default: begin
                // IDLE or ERR2: any data phase in flight finishes now, so a new one may start.
                state_d  = ST_IDLE;
                active_d = 1'b0;
                hready_d = 1'b1;
                hresp_d  = HRESP_OKAY;
                if (accept_c) begin
                    ctrl_d.write = HWRITE;
                    ctrl_d.size  = HSIZE;
                    ctrl_d.offs  = HADDR[1:0];
                    idx_d        = haddr_idx_c;
                    if (err_c) begin
                        state_d  = ST_ERR1;
                        hready_d = 1'b0;
                        hresp_d  = HRESP_ERROR;
                    end else begin
                        active_d = 1'b1;
                        if (WAIT_STATES == 0) begin
                            if (!HWRITE) begin
                                hrdata_d = rd_merged_c;
                            end
                        end else begin
                            state_d  = ST_WAIT;
                            hready_d = 1'b0;
                            cnt_d    = CNT_W'(WAIT_STATES - 1);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            hrdata_q <= hrdata_d;
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hready_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: three instances (1, 0 and 3 wait states) on one shared bus,
// each transfer checked against a word-array memory model and timing expectations.
module tb_ahb_mem_slave;
    import ahb_mem_slave_pkg::*;

    localparam int unsigned MEM_WORDS = 256;
    localparam int N_INST = 3;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  trans;
        logic        sel;
    } xfer_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [2:0]  hsel;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;

    logic [N_INST-1:0]       hreadyout;
    logic [N_INST-1:0][1:0]  hresp;
    logic [N_INST-1:0][31:0] hrdata;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mem_m [N_INST][MEM_WORDS];
    logic [31:0] hold_m [N_INST];
    xfer_t q[$];

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        ahb_mem_slave #(
            .MEM_WORDS  (MEM_WORDS),
            .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .HCLK     (HCLK),
            .HRESET   (HRESET),
            .HSEL     (hsel[g]),
            .HADDR    (HADDR),
            .HTRANS   (HTRANS),
            .HWRITE   (HWRITE),
            .HSIZE    (HSIZE),
            .HBURST   (HBURST),
            .HWDATA   (HWDATA),
            .HREADY   (hreadyout[g]),
            .HRDATA   (hrdata[g]),
            .HREADYOUT(hreadyout[g]),
            .HRESP    (hresp[g])
        );
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    function automatic logic is_err(input logic [31:0] a, input logic [2:0] s);
        return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00)
            || (a >= 32'(MEM_WORDS * 4));
    endfunction

    function automatic void model_write(input int inst, input logic [31:0] a,
                                        input logic [2:0] s, input logic [31:0] d);
        int off = int'(a[1:0]);
        int n = 1 << s;
        for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + n) mem_m[inst][a[9:2]][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    function automatic void push(input logic [31:0] a, input logic w, input logic [2:0] s,
                                 input logic [31:0] d, input logic [1:0] t, input logic sel);
        xfer_t x;
        x.addr = a; x.wr = w; x.size = s; x.wdata = d; x.trans = t; x.sel = sel;
        q.push_back(x);
    endfunction

    // Plays the queued transfers on instance inst as a pipelined master and checks every cycle.
    task automatic run_q(input int inst);
        int ai = 0;
        int di = -1;
        int pi = -1;
        int waits = 0;
        int cyc = 0;
        int limit;
        logic last_rdy = 1'b1;
        logic rdy;
        logic err = 1'b0;
        logic [1:0] exp_resp;
        xfer_t x;
        limit = 8 * q.size() + 16;
        forever begin
            if (last_rdy) begin
                di = pi;
                waits = 0;
                if (di >= 0 && q[di].wr) HWDATA = q[di].wdata;
                if (ai < q.size()) begin
                    x = q[ai];
                    hsel = x.sel ? 3'(1 << inst) : 3'b000;
                    HADDR = x.addr; HTRANS = x.trans; HWRITE = x.wr; HSIZE = x.size;
                    pi = (x.sel && x.trans[1]) ? ai : -1;
                    ai++;
                end else begin
                    hsel = '0; HTRANS = HTRANS_IDLE; pi = -1;
                end
            end
            rdy = hreadyout[inst];
            if (di >= 0) begin
                x = q[di];
                err = is_err(x.addr, x.size);
                exp_resp = err ? HRESP_ERROR : HRESP_OKAY;
                vectors++;
                if (hresp[inst] !== exp_resp) begin
                    miscompares++;
                    $display("FAIL hresp inst%0d xfer%0d addr=%h: got %b want %b",
                             inst, di, x.addr, hresp[inst], exp_resp);
                end
                if (!rdy) begin
                    waits++;
                end else begin
                    vectors++;
                    if (waits != (err ? 1 : ws_of(inst))) begin
                        miscompares++;
                        $display("FAIL wait_count inst%0d xfer%0d addr=%h: got %0d want %0d",
                                 inst, di, x.addr, waits, err ? 1 : ws_of(inst));
                    end
                    if (!err && !x.wr) hold_m[inst] = mem_m[inst][x.addr[9:2]];
                end
            end else begin
                vectors++;
                if (rdy !== 1'b1 || hresp[inst] !== HRESP_OKAY) begin
                    miscompares++;
                    $display("FAIL idle_resp inst%0d: got ready=%b resp=%b want ready=1 resp=00",
                             inst, rdy, hresp[inst]);
                end
            end
            vectors++;
            if (hrdata[inst] !== hold_m[inst]) begin
                miscompares++;
                $display("FAIL hrdata inst%0d xfer%0d: got %h want %h",
                         inst, di, hrdata[inst], hold_m[inst]);
            end
            if (di >= 0 && rdy && !err && x.wr) model_write(inst, x.addr, x.size, x.wdata);
            last_rdy = rdy;
            if (rdy && pi < 0 && ai >= q.size()) break;
            @(posedge HCLK); #1;
            cyc++;
            if (cyc > limit) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout inst%0d: got %0d cycles want <= %0d", inst, cyc, limit);
                break;
            end
        end
        hsel = '0;
        HTRANS = HTRANS_IDLE;
        @(posedge HCLK); #1;
        q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < N_INST; i++) begin
            vectors++;
            if (hreadyout[i] !== 1'b1 || hresp[i] !== HRESP_OKAY || hrdata[i] !== 32'h0) begin
                miscompares++;
                $display("FAIL %s inst%0d: got ready=%b resp=%b rdata=%h want 1/00/00000000",
                         tag, i, hreadyout[i], hresp[i], hrdata[i]);
            end
            hold_m[i] = 32'h0;
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        hsel = '0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
        HSIZE = HSIZE_WORD; HBURST = 3'b000; HWDATA = '0;
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        check_reset_outputs("reset_state");
    endtask

    task automatic test_prefill();
        for (int inst = 0; inst < N_INST; inst++) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) begin
                push(32'(i * 4), 1'b1, HSIZE_WORD, $urandom,
                     (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1);
            end
            run_q(inst);
        end
    endtask

    task automatic test_single_word();
        push(32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF, HTRANS_NONSEQ, 1'b1);
        push(32'h10, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
        run_q(0);
    endtask

    task automatic test_byte_lanes();
        push(32'h20, 1'b1, HSIZE_WORD, 32'h11223344, HTRANS_NONSEQ, 1'b1);
        push(32'h22, 1'b1, HSIZE_BYTE, 32'hFFAAFFFF, HTRANS_NONSEQ, 1'b1);
        push(32'h20, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
        push(32'h26, 1'b1, HSIZE_HALF, 32'h9876FFFF, HTRANS_NONSEQ, 1'b1);
        push(32'h24, 1'b0, HSIZE_BYTE, 32'h0, HTRANS_NONSEQ, 1'b1);
        run_q(0);
    endtask

    task automatic test_error();
        push(32'h401, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
        push(32'h400, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
        push(32'h11, 1'b1, HSIZE_HALF, 32'hFFFFFFFF, HTRANS_NONSEQ, 1'b1);
        push(32'h10, 1'b1, 3'b011, 32'hFFFFFFFF, HTRANS_NONSEQ, 1'b1);
        push(32'h10, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
        push(32'h3FC, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
        run_q(0);
    endtask

    task automatic test_idle_busy();
        push(32'h10, 1'b1, HSIZE_WORD, 32'h12345678, HTRANS_IDLE, 1'b1);
        push(32'h10, 1'b1, HSIZE_WORD, 32'h12345678, HTRANS_BUSY, 1'b1);
        push(32'h10, 1'b1, HSIZE_WORD, 32'h12345678, HTRANS_NONSEQ, 1'b0);
        push(32'h10, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
        run_q(0);
    endtask

    task automatic test_burst();
        HBURST = 3'b011;
        for (int i = 0; i < 4; i++)
            push(32'(32'h40 + 4 * i), 1'b1, HSIZE_WORD, 32'(i),
                 (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1);
        for (int i = 0; i < 4; i++)
            push(32'(32'h40 + 4 * i), 1'b0, HSIZE_WORD, 32'h0,
                 (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1);
        run_q(1);
        HBURST = 3'b000;
    endtask

    task automatic test_back_to_back();
        push(32'h30, 1'b1, HSIZE_WORD, 32'h00000055, HTRANS_NONSEQ, 1'b1);
        push(32'h30, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
        push(32'h32, 1'b1, HSIZE_HALF, 32'hBEEF0000, HTRANS_NONSEQ, 1'b1);
        push(32'h30, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
        push(32'h31, 1'b1, HSIZE_BYTE, 32'h0000A500, HTRANS_NONSEQ, 1'b1);
        push(32'h30, 1'b0, HSIZE_BYTE, 32'h0, HTRANS_NONSEQ, 1'b1);
        run_q(1);
        push(32'h34, 1'b1, HSIZE_WORD, 32'hA5A5A5A5, HTRANS_NONSEQ, 1'b1);
        push(32'h34, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
        run_q(2);
    endtask

    task automatic test_reset_mid_wait();
        push(32'h8, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
        run_q(2);
        hsel = 3'b100; HADDR = 32'h8; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
        @(posedge HCLK); #1;
        hsel = '0; HTRANS = HTRANS_IDLE; HWDATA = 32'hCAFEF00D;
        vectors++;
        if (hreadyout[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL wait1_ready: got %b want 0", hreadyout[2]);
        end
        @(posedge HCLK); #1;
        vectors++;
        if (hreadyout[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL wait2_ready: got %b want 0", hreadyout[2]);
        end
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        check_reset_outputs("reset_mid_wait");
        push(32'h8, 1'b0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1'b1);
        run_q(2);
    endtask

    task automatic test_random(input int inst, input int n);
        logic [31:0] a;
        logic [2:0] s;
        logic [1:0] t;
        logic sel;
        int r;
        for (int i = 0; i < n; i++) begin
            s = 3'($urandom_range(0, 2));
            a = 32'($urandom_range(0, MEM_WORDS * 4 - 1)) & ~((32'd1 << s) - 32'd1);
            r = int'($urandom_range(0, 15));
            if (r == 0) s = 3'($urandom_range(3, 7));
            else if (r == 1) a = a | 32'h1;
            else if (r == 2) a = a | (32'($urandom_range(1, 4095)) << 10);
            t = ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
            sel = 1'b1;
            r = int'($urandom_range(0, 15));
            if (r == 0) t = HTRANS_IDLE;
            else if (r == 1) t = HTRANS_BUSY;
            else if (r == 2) sel = 1'b0;
            push(a, 1'($urandom_range(0, 1)), s, $urandom, t, sel);
        end
        run_q(inst);
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_single_word();
        test_byte_lanes();
        test_error();
        test_idle_busy();
        test_burst();
        test_back_to_back();
        test_reset_mid_wait();
        for (int inst = 0; inst < N_INST; inst++) test_random(inst, 200);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 Parameter MEM_WORDS, default 256: number of 32-bit words held; power of two, 16..4096.
REQ-002 Parameter WAIT_STATES, default 1: wait cycles inserted per OKAY data phase, 0..3.
REQ-003 HCLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 HRESET  in  1  reset, synchronous, active-high.
REQ-005 HSEL  in  1  slave select from the decoder.
REQ-006 HADDR  in  32  byte address; only the low log2(MEM_WORDS)+2 bits are decoded.
REQ-007 HTRANS  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 HWRITE  in  1  1 = write.
REQ-009 HSIZE  in  3  transfer size: 000 byte, 001 halfword, 010 word.
REQ-010 HBURST  in  3  burst type; informational only, since each beat carries its own address.
REQ-011 HWDATA  in  32  write data, valid in the data phase.
REQ-012 HREADY  in  1  bus-wide ready; qualifies address-phase sampling.
REQ-013 HRDATA  out  32  read data.
REQ-014 HREADYOUT  out  1  this slave's data-phase ready.
REQ-015 HRESP  out  2  response: OKAY=00, ERROR=01; RETRY and SPLIT are never driven.

Function
REQ-016 The address phase SHALL be accepted only on an edge where HSEL=1, HREADY=1 and HTRANS[1]=1. On acceptance the block latches HADDR, HWRITE and HSIZE, and evaluates an error flag.
REQ-017 The error flag SHALL be set when any of these holds: HSIZE>010; HADDR is misaligned (halfword with HADDR[0]=1, or word with HADDR[1:0]!=00); the word index is ≥ MEM_WORDS.
REQ-018 The FSM SHALL have the states IDLE, WAIT, ERR1 and ERR2. In IDLE, HREADYOUT=1 and HRESP=OKAY.
REQ-019 An accepted OKAY transfer SHALL move to WAIT for exactly WAIT_STATES cycles with HREADYOUT=0, then complete with HREADYOUT=1. When WAIT_STATES=0, it SHALL complete in the first data-phase cycle.
REQ-020 An accepted error transfer SHALL go to ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01), then back to IDLE. An accepted error transfer SHALL produce no memory access.
REQ-021 A write SHALL commit on the completing edge of its data phase. Only the byte lanes selected by HSIZE and HADDR[1:0] are written, using little-endian lane mapping.
REQ-022 On a read's completing cycle, HRDATA SHALL present the full 32-bit word, with all lanes driven whatever HSIZE is. Outside that cycle HRDATA SHALL hold its previous value.
REQ-023 Read-after-write to the same word in back-to-back transfers SHALL return the newly written lanes merged with the old lanes, including when WAIT_STATES=0.
REQ-024 IDLE or BUSY with HSEL=1 SHALL give a zero-wait OKAY response and cause no access.
REQ-025 A new address phase accepted in the ERR2 or completing cycle SHALL be pipelined with no idle cycle in between.
REQ-026 A transfer with HSEL=0 SHALL be ignored. An address phase presented while HREADY=0 SHALL NOT be sampled.
REQ-027 Word index arithmetic SHALL use HADDR[log2(MEM_WORDS)+1:2]. Higher address bits take part only in the range check.

Reset
REQ-028 Asserting HRESET on any edge SHALL force IDLE, HREADYOUT=1, HRESP=00, HRDATA=0 and clear the latched controls. An in-flight write SHALL be discarded, even in mid-WAIT.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-030 The HTRANS, HSIZE and HRESP encodings and the FSM state encoding SHALL live in the shared AHB macro header.
REQ-031 Storage SHALL be one sub-module, ahb_mem_array: a synchronous-write RAM with a 4-bit byte enable and asynchronous read, sized by MEM_WORDS.

Verification
REQ-032 Single word: WAIT_STATES=1, write 0xDEADBEEF to 0x10, then read 0x10 → HREADYOUT is low for 1 cycle per transfer, and HRDATA=0xDEADBEEF with HRESP=00.
REQ-033 Byte lanes: word 0x20=0x11223344, then byte write 0xAA to 0x22 → a read of 0x20 returns 0x11AA3344.
REQ-034 Error path: a word read at 0x401 with MEM_WORDS=256 → ERR1 (HREADYOUT=0, HRESP=01) then ERR2 (HREADYOUT=1, HRESP=01). A subsequent read of 0x400 also gives ERROR because it is out of range.
REQ-035 INCR4 burst: WAIT_STATES=0, NONSEQ/SEQ beats writing 0..3 at 0x40..0x4C, then a read burst → four consecutive one-cycle OKAY beats returning 0,1,2,3.
REQ-036 Hazard: WAIT_STATES=0, write 0x55 to 0x30 immediately followed by a read of 0x30 → the read returns 0x00000055.
REQ-037 Reset mid-WAIT: WAIT_STATES=3, write 0xCAFEF00D to 0x8 with HRESET pulsed in the 2nd wait cycle → next cycle HREADYOUT=1 and HRESP=00, and word 0x8 is unchanged.
